// File: rtl/mem_sched.sv
// Byte-serial scheduler sharing one 8-bit RAM port between instruction fetch and load/store.
// Optional macro MEM_SCHED_STARVE_GUARD_EN: lets a waiting fetch in after STARVE_MAX back-to-back MM grants.
module mem_sched #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_a,
    output logic              if_ok,
    output logic [31:0]       if_n,
    input  logic              mm_req,
    input  logic              mm_wr,
    input  logic [1:0]        mm_len,
    input  logic [ADDR_W-1:0] mm_a,
    input  logic [31:0]       mm_n_i,
    output logic              mm_ok,
    output logic [31:0]       mm_n_o,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_wn,
    input  logic [7:0]        mem_rn,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;

    generate
        if (STARVE_MAX < 1) begin : g_starve_max_must_be_positive
        end
    endgenerate

    function automatic logic [1:0] len_last(input logic [1:0] len);
        case (len)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_last;
    logic [1:0]        r_cnt;
    logic              r_own_mm;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rbuf;
    logic              r_if_ok;
    logic              r_mm_ok;
    logic [31:0]       r_if_n;
    logic [31:0]       r_mm_n_o;
    logic [ADDR_W-1:0] r_mem_a;
    logic              r_mem_wr;
    logic [7:0]        r_mem_wn;
    logic              r_busy;

    logic              w_grant_mm;
    logic              w_grant_if;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_a;
    logic [1:0]        w_cnt_inc;
    logic [1:0]        w_lane_prev;
    logic [ADDR_W-1:0] w_next_a;
    logic [31:0]       w_rd_word;

`ifdef MEM_SCHED_STARVE_GUARD_EN
    localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    logic [SW-1:0] r_starve;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_grant_mm = mm_req;
        w_grant_if = if_req && !mm_req;
`ifdef MEM_SCHED_STARVE_GUARD_EN
        if (mm_req && if_req && (r_starve == SW'(STARVE_MAX))) begin
            w_grant_mm = 1'b0;
            w_grant_if = 1'b1;
        end
`endif
    end

    assign w_sel_wr    = w_grant_mm && mm_wr;
    assign w_sel_a     = w_grant_mm ? mm_a : if_a;
    assign w_cnt_inc   = r_cnt + 2'd1;
    assign w_lane_prev = r_cnt - 2'd1;
    assign w_next_a    = r_base + {{(ADDR_W-2){1'b0}}, w_cnt_inc};

    // The final byte arrives during RD_TAIL, so merge it straight into the word being retired.
    always_comb begin
        w_rd_word = r_rbuf;
        w_rd_word[{r_last, 3'b000} +: 8] = mem_rn;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_last   <= 2'd0;
            r_cnt    <= 2'd0;
            r_own_mm <= 1'b0;
            r_wdata  <= '0;
            r_rbuf   <= '0;
            r_if_ok  <= 1'b0;
            r_mm_ok  <= 1'b0;
            r_if_n   <= '0;
            r_mm_n_o <= '0;
            r_mem_a  <= '0;
            r_mem_wr <= 1'b0;
            r_mem_wn <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_if_ok <= 1'b0;
            r_mm_ok <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_mm || w_grant_if) begin
                        r_base   <= w_sel_a;
                        r_last   <= w_grant_mm ? len_last(mm_len) : 2'd3;
                        r_own_mm <= w_grant_mm;
                        r_wdata  <= mm_n_i;
                        r_cnt    <= 2'd0;
                        r_rbuf   <= '0;
                        r_mem_a  <= w_sel_a;
                        r_mem_wr <= w_sel_wr;
                        r_mem_wn <= w_sel_wr ? mm_n_i[7:0] : 8'h00;
                        r_busy   <= 1'b1;
                        r_state  <= w_sel_wr ? WR : RD;
                    end
                end
                RD: begin
                    if (r_cnt != 2'd0)
                        r_rbuf[{w_lane_prev, 3'b000} +: 8] <= mem_rn;
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == r_last) begin
                        r_mem_a <= '0;
                        r_state <= RD_TAIL;
                    end else begin
                        r_mem_a <= w_next_a;
                    end
                end
                RD_TAIL: begin
                    if (r_own_mm)
                        r_mm_n_o <= w_rd_word;
                    else
                        r_if_n <= w_rd_word;
                    r_if_ok <= !r_own_mm;
                    r_mm_ok <= r_own_mm;
                    r_state <= DONE;
                end
                WR: begin
                    if (r_cnt == r_last) begin
                        r_mem_a  <= '0;
                        r_mem_wr <= 1'b0;
                        r_mem_wn <= 8'h00;
                        r_mm_ok  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt    <= w_cnt_inc;
                        r_mem_a  <= w_next_a;
                        r_mem_wn <= r_wdata[{w_cnt_inc, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_SCHED_STARVE_GUARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == IDLE && (w_grant_mm || w_grant_if)) begin
            if (w_grant_mm && if_req)
                r_starve <= r_starve + 1'b1;
            else
                r_starve <= '0;
        end
    end
`endif

    assign if_ok  = r_if_ok;
    assign if_n   = r_if_n;
    assign mm_ok  = r_mm_ok;
    assign mm_n_o = r_mm_n_o;
    assign mem_a  = r_mem_a;
    assign mem_wr = r_mem_wr;
    assign mem_wn = r_mem_wn;
    assign busy   = r_busy;

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: a transaction-level model predicts grant order, ok cycles and data.
module tb_mem_sched;

    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_a = '0;
    logic        if_ok;
    logic [31:0] if_n;
    logic        mm_req = 1'b0;
    logic        mm_wr = 1'b0;
    logic [1:0]  mm_len = '0;
    logic [31:0] mm_a = '0;
    logic [31:0] mm_n_i = '0;
    logic        mm_ok;
    logic [31:0] mm_n_o;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wn;
    logic [7:0]  mem_rn = '0;
    logic        busy;

    mem_sched #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_a(if_a), .if_ok(if_ok), .if_n(if_n),
        .mm_req(mm_req), .mm_wr(mm_wr), .mm_len(mm_len), .mm_a(mm_a),
        .mm_n_i(mm_n_i), .mm_ok(mm_ok), .mm_n_o(mm_n_o),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_wn(mem_wn), .mem_rn(mem_rn),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  len;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    typedef struct {
        bit          own_mm;
        bit          is_rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_if_n = '0;
    logic [31:0] exp_mm_n = '0;
    int          model_starve = 0;
    int          n_checks = 0;
    int          n_err = 0;

    txn_t        mm_tx[8];
    int          n_mm;
    bit          has_if;
    bit          if_drop;
    logic [31:0] if_addr;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic int len_bytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
        return w;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, 63));
            1:       return 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
            default: return 32'h100 + 32'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr  = 1'($urandom_range(0, 1));
        t.len = 2'($urandom_range(0, 3));
        t.a   = rand_addr();
        t.d   = $urandom;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    task automatic drive_mm(input txn_t t);
        mm_wr  = t.wr;
        mm_len = t.len;
        mm_a   = t.a;
        mm_n_i = t.d;
    endtask

    // External RAM: writes land on the edge, read data appears one cycle after its address.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_wn;
        mem_rn <= ram_rd(mem_a);
    end

    // Monitor: every ok pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (if_ok || mm_ok)) begin
            check("ok_exclusive", 32'(if_ok & mm_ok), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_ok: got if_ok=%b mm_ok=%b at cycle %0d expected none", if_ok, mm_ok, cyc);
            end else begin
                e = sb.pop_front();
                check("ok_owner", 32'(mm_ok), 32'(e.own_mm));
                check("ok_cycle", 32'(cyc), 32'(e.cyc));
                if (e.is_rd) begin
                    if (e.own_mm) exp_mm_n = e.data;
                    else          exp_if_n = e.data;
                end
                check("if_n", if_n, exp_if_n);
                check("mm_n_o", mm_n_o, exp_mm_n);
                check("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic run_session();
        int   c, t, mi_m, mi, if_g, budget, n, lat;
        int   mm_g[8];
        bit   if_pend, if_done, pick_if;
        exp_t e;
        txn_t tx;

        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mem_a", mem_a, 32'd0);
        check("idle_mem_wr", 32'(mem_wr), 32'd0);

        // Model: walk the grants in priority order; each grant follows the previous ok by one IDLE cycle.
        c = cyc; t = c; mi_m = 0; if_pend = has_if; if_g = 0;
        while (mi_m < n_mm || if_pend) begin
            if (mi_m < n_mm && if_pend) begin
`ifdef MEM_SCHED_STARVE_GUARD_EN
                pick_if = (model_starve == STARVE_MAX);
`else
                pick_if = 1'b0;
`endif
            end else begin
                pick_if = if_pend;
            end
            if (pick_if) begin
                if_g = t; if_pend = 1'b0; model_starve = 0;
                e.own_mm = 1'b0; e.is_rd = 1'b1;
                e.data = ref_word(if_addr, 4);
                e.cyc = t + 6;
                t += 7;
            end else begin
                tx = mm_tx[mi_m]; mm_g[mi_m] = t;
                model_starve = if_pend ? model_starve + 1 : 0;
                n = len_bytes(tx.len);
                e.own_mm = 1'b1; e.is_rd = !tx.wr;
                if (tx.wr) begin
                    for (int i = 0; i < n; i++) ref_mem[tx.a + 32'(i)] = tx.d[8*i +: 8];
                    e.data = '0;
                    lat = n + 1;
                end else begin
                    e.data = ref_word(tx.a, n);
                    lat = n + 2;
                end
                e.cyc = t + lat;
                t += lat + 1;
                mi_m++;
            end
            sb.push_back(e);
        end

        mi = 0; if_done = !has_if; budget = 0;
        if (n_mm > 0) begin
            mm_req = 1'b1;
            drive_mm(mm_tx[0]);
        end
        if_req = has_if;
        if_a   = if_addr;
        while (!(mi == n_mm && if_done)) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                n_checks++;
                n_err++;
                $display("FAIL session_timeout: got %0d of %0d mm oks, if_done=%b expected all", mi, n_mm, if_done);
                break;
            end
            if (mm_ok && mi < n_mm) begin
                mi++;
                if (mi == n_mm) mm_req = 1'b0;
                else            drive_mm(mm_tx[mi]);
            end
            if (if_ok && !if_done) begin
                if_done = 1'b1;
                if_req  = 1'b0;
            end
            // Latched inputs are fair game for garbage once their transfer has been granted.
            if (mi < n_mm && cyc > mm_g[mi]) begin
                mm_wr  = 1'($urandom_range(0, 1));
                mm_len = 2'($urandom_range(0, 3));
                mm_a   = $urandom;
                mm_n_i = $urandom;
            end
            if (!if_done && cyc > if_g) begin
                if_a = $urandom;
                if (if_drop && cyc == if_g + 2) if_req = 1'b0;
            end
        end
        mm_req = 1'b0;
        if_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_if_ok", 32'(if_ok), 32'd0);
        check("rst_mm_ok", 32'(mm_ok), 32'd0);
        check("rst_if_n", if_n, 32'd0);
        check("rst_mm_n_o", mm_n_o, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_wn", 32'(mem_wn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fetch of a known instruction word.
        preset(32'h100, 8'h13); preset(32'h101, 8'h05);
        preset(32'h102, 8'h10); preset(32'h103, 8'h00);
        n_mm = 0; has_if = 1'b1; if_addr = 32'h100; if_drop = 1'b0;
        run_session();
        check("fetch_word", if_n, 32'h0010_0513);

        // Word store, then inspect the RAM bytes.
        mm_tx[0] = '{wr: 1'b1, len: 2'b10, a: 32'h20, d: 32'hDEAD_BEEF};
        n_mm = 1; has_if = 1'b0;
        run_session();
        check("store_b0", 32'(ram_rd(32'h20)), 32'hEF);
        check("store_b1", 32'(ram_rd(32'h21)), 32'hBE);
        check("store_b2", 32'(ram_rd(32'h22)), 32'hAD);
        check("store_b3", 32'(ram_rd(32'h23)), 32'hDE);

        // Halfword load that wraps the address space.
        preset(32'hFFFF_FFFF, 8'h34); preset(32'h0, 8'h12);
        mm_tx[0] = '{wr: 1'b0, len: 2'b01, a: 32'hFFFF_FFFF, d: 32'h0};
        n_mm = 1; has_if = 1'b0;
        run_session();
        check("load_wrap", mm_n_o, 32'h0000_1234);

        // Both requesting: MM byte load first, then the fetch.
        mm_tx[0] = '{wr: 1'b0, len: 2'b00, a: 32'h20, d: 32'h0};
        n_mm = 1; has_if = 1'b1; if_addr = 32'h20;
        run_session();
        check("simul_mm", mm_n_o, 32'h0000_00EF);
        check("simul_if", if_n, 32'hDEAD_BEEF);

        // Reset during cycle 2 of a word store.
        @(negedge clk);
        mm_req = 1'b1; mm_wr = 1'b1; mm_len = 2'b10; mm_a = 32'h40; mm_n_i = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mm_req = 1'b0;
        #1;
        check("rstmid_mem_wr", 32'(mem_wr), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_if_ok", 32'(if_ok), 32'd0);
        check("rstmid_mm_ok", 32'(mm_ok), 32'd0);
        check("rstmid_mem_a", mem_a, 32'd0);
        ref_mem[32'h40] = 8'h0D;
        exp_if_n = '0; exp_mm_n = '0; model_starve = 0;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_b0", 32'(ram_rd(32'h40)), 32'h0D);
        check("rstmid_b1", 32'(ram_rd(32'h41)), 32'(dflt(32'h41)));
        n_mm = 0; has_if = 1'b1; if_addr = 32'h40; if_drop = 1'b0;
        run_session();

        // Fetch waiting behind a stream of MM requests.
        for (int i = 0; i < 6; i++) mm_tx[i] = rand_txn();
        n_mm = 6; has_if = 1'b1; if_addr = rand_addr(); if_drop = 1'b0;
        run_session();

        repeat (40) begin
            n_mm = $urandom_range(0, 3);
            has_if = 1'($urandom_range(0, 1));
            if (n_mm == 0) has_if = 1'b1;
            for (int i = 0; i < n_mm; i++) mm_tx[i] = rand_txn();
            if_addr = rand_addr();
            if_drop = 1'($urandom_range(0, 1));
            run_session();
        end

        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        foreach (ref_mem[a]) check($sformatf("ref_mem[%h]", a), 32'(ram_rd(a)), 32'(ref_mem[a]));
        foreach (ram[a]) check($sformatf("ram[%h]", a), 32'(ram[a]), 32'(ref_rd(a)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
